// File: rtl/up_mem_map_host.sv
// up_mem_map_host: host-side peripheral for the up_core memory-map port.
// Host bytes are buffered in a small FIFO, loaded into the core one at a
// time and followed by an active-low interrupt pulse plus a hold-off gap.
// Core writes to mem_map_out are captured and offered back to the host.
// Optional capture path: define UP_MEM_MAP_HOST_CAPTURE_EN to build it;
// otherwise out_valid/out_data/overrun are tied low.
// The interrupt line is named int_n because "int" is a reserved word.
module up_mem_map_host #(
    parameter int FIFO_DEPTH = 4,
    parameter int INT_LEN    = 4,
    parameter int HOLDOFF    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       mem_map_load,
    output logic [7:0] mem_map_in,
    output logic       int_n,
    input  logic [7:0] mem_map_out,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       overrun
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int TMAX = (INT_LEN > HOLDOFF) ? INT_LEN : HOLDOFF;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, IRQ, HOLD} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          host_ready_q;
    logic          push, pop;

    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic          load_q, int_q;
    logic [7:0]    min_q;

    assign push    = host_valid & host_ready_q;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign count_d = count_q + CW'(push) - CW'(pop);

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_data;
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            host_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q      <= count_d;
            host_ready_q <= (count_d < CW'(FIFO_DEPTH));
        end
    end

    // Delivery FSM: pop, one-cycle load strobe, interrupt pulse, hold-off gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            load_q  <= 1'b0;
            int_q   <= 1'b1;
            min_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= LOAD;
                    load_q  <= 1'b1;
                    min_q   <= mem_q[rd_ptr_q];
                end
                LOAD: begin
                    state_q <= IRQ;
                    load_q  <= 1'b0;
                    int_q   <= 1'b0;
                    tmr_q   <= '0;
                end
                IRQ: if (tmr_q == TW'(INT_LEN - 1)) begin
                    state_q <= HOLD;
                    int_q   <= 1'b1;
                    tmr_q   <= '0;
                end else begin
                    tmr_q <= tmr_q + TW'(1);
                end
                HOLD: if (tmr_q == TW'(HOLDOFF - 1)) begin
                    state_q <= IDLE;
                    tmr_q   <= '0;
                end else begin
                    tmr_q <= tmr_q + TW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host_ready   = host_ready_q;
    assign mem_map_load = load_q;
    assign mem_map_in   = min_q;
    assign int_n        = int_q;

`ifdef UP_MEM_MAP_HOST_CAPTURE_EN
    logic [7:0] prev_q, out_data_q;
    logic       out_valid_q, overrun_q;
    logic       chg;

    assign chg = (mem_map_out != prev_q);

    // Change detector on mem_map_out; a new byte always wins over a pop
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_q <= mem_map_out;
            if (chg) begin
                out_data_q  <= mem_map_out;
                out_valid_q <= 1'b1;
                if (out_valid_q && !out_ready) overrun_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;
`else
    logic unused_capture;
    assign unused_capture = ^{out_ready, mem_map_out};
    assign out_valid      = 1'b0;
    assign out_data       = 8'h00;
    assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_up_mem_map_host.sv
// Testbench for up_mem_map_host: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_up_mem_map_host;

    localparam int DEPTH   = 4;
    localparam int INT_LEN = 4;
    localparam int HOLDOFF = 16;
    localparam int PERIOD  = 2 + INT_LEN + HOLDOFF;
`ifdef UP_MEM_MAP_HOST_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready;
    logic       mem_map_load;
    logic [7:0] mem_map_in;
    logic       int_n;
    logic [7:0] mem_map_out = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       overrun;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] load_q[$];
    int         load_cyc[$];

    up_mem_map_host #(.FIFO_DEPTH(DEPTH), .INT_LEN(INT_LEN), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .mem_map_load(mem_map_load), .mem_map_in(mem_map_in), .int_n(int_n),
        .mem_map_out(mem_map_out), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // record every delivered byte and the cycle it was strobed
    always @(negedge clk) begin
        if (!rst && mem_map_load) begin
            load_q.push_back(mem_map_in);
            load_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_valid = 1'b0;
        mem_map_out = 8'h00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        load_q.delete();
        load_cyc.delete();
    endtask

    // push n bytes starting at first, one per accepted handshake
    task automatic push_seq(input int n, input logic [7:0] first);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 200) begin
            host_valid = 1'b1;
            host_data  = first + 8'(k);
            if (host_ready) k++;
            tick();
            guard++;
        end
        host_valid = 1'b0;
        total++;
        if (k != n) $display("FAIL push_seq: accepted %0d of %0d", k, n);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({host_ready, mem_map_load, mem_map_in, int_n} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            $display("FAIL reset_delivery: ready=%b load=%b in=%h int=%b", host_ready, mem_map_load, mem_map_in, int_n);
        end else passed++;
        total++;
        if ({out_valid, out_data, overrun} !== 10'h0) begin
            $display("FAIL reset_capture: valid=%b data=%h ovr=%b", out_valid, out_data, overrun);
        end else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic exp_load, exp_int;
        do_reset();
        host_valid = 1'b1;
        host_data  = 8'hA5;
        tick();
        host_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_load = (i == 1);
            exp_int  = !(i >= 2 && i <= 1 + INT_LEN);
            total++;
            if (mem_map_load !== exp_load || int_n !== exp_int) begin
                $display("FAIL single_step%0d: load=%b int=%b want load=%b int=%b", i, mem_map_load, int_n, exp_load, exp_int);
            end else passed++;
            if (i >= 1) begin
                total++;
                if (mem_map_in !== 8'hA5) $display("FAIL single_data%0d: got %h want a5", i, mem_map_in);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_seq(5, 8'h01);
        total++;
        if (host_ready !== 1'b0) $display("FAIL b2b_full: ready=%b want 0", host_ready);
        else passed++;
        repeat (5 * PERIOD + 5) tick();
        total++;
        if (load_q.size() != 5) $display("FAIL b2b_count: got %0d want 5", load_q.size());
        else passed++;
        for (int i = 0; i < 5 && i < load_q.size(); i++) begin
            total++;
            if (load_q[i] !== 8'(i + 1)) $display("FAIL b2b_data%0d: got %h want %h", i, load_q[i], 8'(i + 1));
            else passed++;
            if (i > 0) begin
                total++;
                if (load_cyc[i] - load_cyc[i-1] != PERIOD)
                    $display("FAIL b2b_gap%0d: got %0d want %0d", i, load_cyc[i] - load_cyc[i-1], PERIOD);
                else passed++;
            end
        end
        total++;
        if (host_ready !== 1'b1) $display("FAIL b2b_drain_ready: ready=%b want 1", host_ready);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        do_reset();
        push_seq(3, 8'h40);
        while (int_n !== 1'b0 && guard < 40) begin
            tick();
            guard++;
        end
        total++;
        if (int_n !== 1'b0) $display("FAIL rstmid_irq: int never went low");
        else passed++;
        rst = 1'b1;
        tick();
        total++;
        if ({int_n, mem_map_load, host_ready, mem_map_in} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            $display("FAIL rstmid_state: int=%b load=%b ready=%b in=%h", int_n, mem_map_load, host_ready, mem_map_in);
        end else passed++;
        rst = 1'b0;
        load_q.delete();
        load_cyc.delete();
        repeat (3 * PERIOD) tick();
        total++;
        if (load_q.size() != 0 || int_n !== 1'b1) $display("FAIL rstmid_flush: loads=%0d int=%b want 0 loads int=1", load_q.size(), int_n);
        else passed++;
    endtask

    task automatic test_capture();
        do_reset();
        mem_map_out = 8'h3C;
        tick();
        total++;
        if ({out_valid, out_data, overrun} !== {CAP, CAP ? 8'h3C : 8'h00, 1'b0})
            $display("FAIL cap_first: valid=%b data=%h ovr=%b", out_valid, out_data, overrun);
        else passed++;
        mem_map_out = 8'h7E;
        tick();
        total++;
        if ({out_valid, out_data, overrun} !== {CAP, CAP ? 8'h7E : 8'h00, CAP})
            $display("FAIL cap_overrun: valid=%b data=%h ovr=%b", out_valid, out_data, overrun);
        else passed++;
    endtask

    task automatic test_capture_handshake();
        do_reset();
        mem_map_out = 8'h11;
        tick();
        out_ready   = 1'b1;
        mem_map_out = 8'h22;
        tick();
        total++;
        if ({out_valid, out_data, overrun} !== {CAP, CAP ? 8'h22 : 8'h00, 1'b0})
            $display("FAIL cap_coincide: valid=%b data=%h ovr=%b", out_valid, out_data, overrun);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL cap_consume: valid=%b ovr=%b want 0 0", out_valid, overrun);
        else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] m_prev = 8'h00, m_data = 8'h00;
        logic       m_valid = 1'b0, m_ovr = 1'b0;
        int errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (out_valid !== (CAP & m_valid) || out_data !== (CAP ? m_data : 8'h00) || overrun !== (CAP & m_ovr)) begin
                errs++;
                if (errs < 5) $display("FAIL rand_cap c%0d: valid=%b data=%h ovr=%b want %b %h %b",
                                       c, out_valid, out_data, overrun, CAP & m_valid, CAP ? m_data : 8'h00, CAP & m_ovr);
            end
            host_valid = ($urandom_range(0, 3) == 0);
            host_data  = 8'($urandom);
            if (host_valid && host_ready) exp_q.push_back(host_data);
            if ($urandom_range(0, 3) == 0) mem_map_out = 8'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 1) == 1);
            if (mem_map_out != m_prev) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                m_data  = mem_map_out;
                m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_prev = mem_map_out;
            tick();
        end
        host_valid = 1'b0;
        out_ready  = 1'b0;
        total++;
        if (errs != 0) $display("FAIL rand_cap_total: %0d cycle errors want 0", errs);
        else passed++;
        repeat ((DEPTH + 2) * PERIOD + 10) tick();
        total++;
        if (load_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d loads want %0d", load_q.size(), exp_q.size());
        else passed++;
        errs = 0;
        for (int i = 0; i < exp_q.size() && i < load_q.size(); i++) begin
            if (load_q[i] !== exp_q[i]) errs++;
            if (i > 0 && load_cyc[i] - load_cyc[i-1] < PERIOD) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL rand_order: %0d data/gap errors want 0", errs);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_capture();
        test_capture_handshake();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
